// File: rtl/synth_pkg.sv
// Shared constants and types for the synth voice datapath.
package synth_pkg;
  localparam int DATA_W   = 8;
  localparam int N_VOICES = 24;
  localparam int SEL_W    = 5;

  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/demux_24out_chan_reg.sv
// One channel storage register: synchronous clear, load when enabled, hold otherwise.
module demux_chan_reg
  import synth_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst)
      r_q <= '0;
    else if (en)
      r_q <= d;
  end

  assign q = r_q;

endmodule

// File: rtl/demux_24out.sv
// Registered 1-to-24 demultiplexer: each edge the input lands in the slot chosen by sel;
// every other slot holds, so each output is a per-voice storage register.
module demux_24out #(
  parameter int WIDTH = synth_pkg::DATA_W,
  parameter int N_OUT = synth_pkg::N_VOICES,
  parameter int SEL_W = synth_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic [WIDTH-1:0] out9,
  output logic [WIDTH-1:0] out10,
  output logic [WIDTH-1:0] out11,
  output logic [WIDTH-1:0] out12,
  output logic [WIDTH-1:0] out13,
  output logic [WIDTH-1:0] out14,
  output logic [WIDTH-1:0] out15,
  output logic [WIDTH-1:0] out16,
  output logic [WIDTH-1:0] out17,
  output logic [WIDTH-1:0] out18,
  output logic [WIDTH-1:0] out19,
  output logic [WIDTH-1:0] out20,
  output logic [WIDTH-1:0] out21,
  output logic [WIDTH-1:0] out22,
  output logic [WIDTH-1:0] out23
);

  logic [WIDTH-1:0] w_regs [N_OUT];
  logic [N_OUT-1:0] w_en;

  // sel values 24..31 match no channel, so out-of-range selects write nothing.
  for (genvar k = 0; k < N_OUT; k++) begin : g_chan
    assign w_en[k] = (sel == SEL_W'(k));

    demux_chan_reg #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk(clk),
      .rst(rst),
      .en (w_en[k]),
      .d  (in),
      .q  (w_regs[k])
    );
  end

  assign out0  = w_regs[0];
  assign out1  = w_regs[1];
  assign out2  = w_regs[2];
  assign out3  = w_regs[3];
  assign out4  = w_regs[4];
  assign out5  = w_regs[5];
  assign out6  = w_regs[6];
  assign out7  = w_regs[7];
  assign out8  = w_regs[8];
  assign out9  = w_regs[9];
  assign out10 = w_regs[10];
  assign out11 = w_regs[11];
  assign out12 = w_regs[12];
  assign out13 = w_regs[13];
  assign out14 = w_regs[14];
  assign out15 = w_regs[15];
  assign out16 = w_regs[16];
  assign out17 = w_regs[17];
  assign out18 = w_regs[18];
  assign out19 = w_regs[19];
  assign out20 = w_regs[20];
  assign out21 = w_regs[21];
  assign out22 = w_regs[22];
  assign out23 = w_regs[23];

endmodule

// File: tb/tb_demux_24out.sv
// Bench for demux_24out: table of directed vectors plus hand sequences, every cycle
// compared against a 24-entry expected image queued when the stimulus is driven.
module tb_demux_24out;

  typedef struct {
    logic        r;
    logic [7:0]  d;
    logic [4:0]  s;
    int          k;
    logic [7:0]  kv;
    string       name;
  } vec_t;

  typedef struct {
    logic [23:0][7:0] v;
    int               k;
    logic [7:0]       kv;
    string            name;
  } exp_t;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_in;
  logic [4:0] i_sel;
  wire  [7:0] w_out [24];

  logic [23:0][7:0] model;
  exp_t             sb[$];
  vec_t             tbl[38];
  int               n_vec = 0;
  int               n_err = 0;

  always #5 clk = ~clk;

  demux_24out dut (
    .clk(clk), .rst(i_rst), .in(i_in), .sel(i_sel),
    .out0(w_out[0]),   .out1(w_out[1]),   .out2(w_out[2]),   .out3(w_out[3]),
    .out4(w_out[4]),   .out5(w_out[5]),   .out6(w_out[6]),   .out7(w_out[7]),
    .out8(w_out[8]),   .out9(w_out[9]),   .out10(w_out[10]), .out11(w_out[11]),
    .out12(w_out[12]), .out13(w_out[13]), .out14(w_out[14]), .out15(w_out[15]),
    .out16(w_out[16]), .out17(w_out[17]), .out18(w_out[18]), .out19(w_out[19]),
    .out20(w_out[20]), .out21(w_out[21]), .out22(w_out[22]), .out23(w_out[23])
  );

  task automatic check_front();
    exp_t e;
    int   bad;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard: queue empty, required one pending entry");
      return;
    end
    e = sb.pop_front();
    bad = -1;
    for (int k = 0; k < 24; k++)
      if (bad < 0 && w_out[k] !== e.v[k]) bad = k;
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s: out%0d = %02h, required %02h", e.name, bad, w_out[bad], e.v[bad]);
    end
    if (e.k >= 0) begin
      n_vec++;
      if (w_out[e.k] !== e.kv) begin
        n_err++;
        $display("FAIL %s spot: out%0d = %02h, required %02h", e.name, e.k, w_out[e.k], e.kv);
      end
    end
  endtask

  task automatic apply(input logic r, input logic [7:0] d, input logic [4:0] s,
                       input int chk_k, input logic [7:0] chk_v, input string name);
    exp_t e;
    i_rst = r; i_in = d; i_sel = s;
    if (r) model = '0;
    else if (s < 5'd24) model[s] = d;
    e.v = model; e.k = chk_k; e.kv = chk_v; e.name = name;
    sb.push_back(e);
    @(posedge clk); #1;
    check_front();
  endtask

  initial begin
    logic [7:0] oor_v;
    i_rst = 1'b0; i_in = '0; i_sel = '0;
    model = '0;

    tbl[0] = '{1'b1, 8'hFF, 5'd0, 0, 8'h00, "reset0"};
    tbl[1] = '{1'b1, 8'hFF, 5'd0, 23, 8'h00, "reset1"};
    for (int k = 0; k < 24; k++)
      tbl[2+k] = '{1'b0, 8'(k + 8'h10), 5'(k), k, 8'(k + 8'h10), "sweep"};
    tbl[26] = '{1'b0, 8'hA5, 5'd5, 5, 8'hA5, "hold_a5"};
    tbl[27] = '{1'b0, 8'h3C, 5'd5, 5, 8'h3C, "hold_3c"};
    tbl[28] = '{1'b0, 8'h7E, 5'd5, 5, 8'h7E, "hold_7e"};
    tbl[29] = '{1'b0, 8'h01, 5'd5, 5, 8'h01, "hold_01"};
    for (int j = 0; j < 8; j++) begin
      oor_v = (j == 5) ? 8'h01 : 8'(j + 8'h10);
      tbl[30+j] = '{1'b0, 8'hEE, 5'(24 + j), j, oor_v, "out_of_range"};
    end

    for (int i = 0; i < 38; i++)
      apply(tbl[i].r, tbl[i].d, tbl[i].s, tbl[i].k, tbl[i].kv, tbl[i].name);

    // Reset wins over a write in the same cycle; the write lands once rst drops.
    apply(1'b1, 8'h55, 5'd23, 23, 8'h00, "mid_reset");
    apply(1'b0, 8'h55, 5'd23, 23, 8'h55, "after_reset");

    for (int s = 0; s < 24; s++)
      for (int r = 0; r < 4; r++)
        apply(1'b0, 8'($urandom_range(0, 255)), 5'(s), -1, 8'h00, "random");

    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
